// File: rtl/rom_loader_pkg.sv
// Shared types for the multi-segment flash-to-SRAM loader: FSM encodings, SRAM lane codes
// and the per-byte cycle cost of the copy and verify passes.
package rom_loader_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SEG_INIT = 4'd1,
        FL_RD    = 4'd2,
        WR_SETUP = 4'd3,
        WR_PULSE = 4'd4,
        WR_HOLD  = 4'd5,
        VF_FL_RD = 4'd6,
        VF_SR_RD = 4'd7,
        NEXT_SEG = 4'd8,
        DONE     = 4'd9,
        ERR      = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        P_IDLE   = 3'd0,
        P_WSETUP = 3'd1,
        P_WPULSE = 3'd2,
        P_WHOLD  = 3'd3,
        P_RD1    = 3'd4,
        P_RD2    = 3'd5
    } port_phase_t;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Copy: flash access plus 3-cycle write; verify: flash access plus 2-cycle read.
    function automatic int unsigned byte_cycles(input int unsigned fl_wait, input logic verify_pass);
        return verify_pass ? fl_wait + 3 : fl_wait + 4;
    endfunction

endpackage

// File: rtl/rom_loader_mc_sram_byte_port.sv
// Byte-lane SRAM access engine: 3-cycle write (setup/pulse/hold) or 2-cycle read.
// A request is accepted only while idle; ack marks the final phase of the access.
module sram_byte_port
    import rom_loader_pkg::*;
#(
    parameter int SR_AW = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             wr_req,
    input  logic             rd_req,
    input  logic [SR_AW-1:0] req_addr,
    input  logic             req_lane,
    input  logic [7:0]       req_wdat,
    output logic             ack,
    output logic [7:0]       rd_dat,
    output logic [SR_AW-1:0] o_sram_addr,
    output logic [15:0]      o_sram_wdata,
    input  logic [15:0]      i_sram_rdata,
    output logic             o_sram_oe_n,
    output logic             o_sram_we_n,
    output logic             o_sram_ub_n,
    output logic             o_sram_lb_n
);

    port_phase_t phase, phase_d;
    logic        lane_q;
    logic        active;

    always_comb begin
        phase_d = phase;
        unique case (phase)
            P_IDLE: begin
                if (wr_req) begin
                    phase_d = P_WSETUP;
                end else if (rd_req) begin
                    phase_d = P_RD1;
                end
            end
            P_WSETUP: phase_d = P_WPULSE;
            P_WPULSE: phase_d = P_WHOLD;
            P_WHOLD:  phase_d = P_IDLE;
            P_RD1:    phase_d = P_RD2;
            P_RD2:    phase_d = P_IDLE;
            default:  phase_d = P_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            phase        <= P_IDLE;
            lane_q       <= LANE_LO;
            o_sram_addr  <= '0;
            o_sram_wdata <= '0;
        end else begin
            phase <= phase_d;
            if (phase == P_IDLE && (wr_req || rd_req)) begin
                o_sram_addr <= req_addr;
                lane_q      <= req_lane;
                if (wr_req) begin
                    o_sram_wdata <= {req_wdat, req_wdat};
                end
            end
        end
    end

    assign active = (phase != P_IDLE);
    assign ack    = (phase == P_WHOLD) || (phase == P_RD2);
    assign rd_dat = (lane_q == LANE_HI) ? i_sram_rdata[15:8] : i_sram_rdata[7:0];

    // Reset kills an in-flight write pulse without waiting for the clock edge.
    assign o_sram_we_n = (phase != P_WPULSE) || i_rst;
    assign o_sram_oe_n = !((phase == P_RD1) || (phase == P_RD2));
    assign o_sram_lb_n = !(active && lane_q == LANE_LO);
    assign o_sram_ub_n = !(active && lane_q == LANE_HI);

endmodule

// File: rtl/rom_loader_mc.sv
// Multi-segment flash-to-SRAM copy engine with optional readback verify and retry;
// holds the NES core in reset until every segment has been loaded (and verified).
module rom_loader_mc
    import rom_loader_pkg::*;
#(
    parameter int FL_AW      = 23,
    parameter int SR_AW      = 20,
    parameter int SEG_LEN_W  = 16,
    parameter int N_SEG      = 2,
    parameter int FL_WAIT    = 3,
    parameter int VERIFY     = 1,
    parameter int MAX_RETRY  = 2,
    parameter int AUTO_START = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [N_SEG*FL_AW-1:0]     i_seg_fl_base,
    input  logic [N_SEG*SR_AW-1:0]     i_seg_sr_base,
    input  logic [N_SEG*SEG_LEN_W-1:0] i_seg_len,
    output logic [FL_AW-1:0]           o_fl_addr,
    input  logic [7:0]                 i_fl_rdata,
    output logic [SR_AW-1:0]           o_sram_addr,
    output logic [15:0]                o_sram_wdata,
    input  logic [15:0]                i_sram_rdata,
    output logic                       o_sram_oe_n,
    output logic                       o_sram_we_n,
    output logic                       o_sram_ub_n,
    output logic                       o_sram_lb_n,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err,
    output logic [2:0]                 o_err_seg,
    output logic                       o_nes_rstn
);

    localparam int              RT_W        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RT_W-1:0] MAX_RETRY_C = RT_W'(MAX_RETRY);
    localparam logic [7:0]      FL_WAIT_C   = 8'(FL_WAIT);
    localparam logic [2:0]      LAST_SEG    = 3'(N_SEG - 1);

    state_t                     state, state_d;
    logic [2:0]                 seg, seg_d;
    logic [SEG_LEN_W-1:0]       idx, idx_d, idx_inc;
    logic [RT_W-1:0]            retry, retry_d;
    logic [7:0]                 wcnt, wcnt_d;
    logic [7:0]                 fl_byte, fl_byte_d;
    logic [FL_AW-1:0]           fl_addr_d;
    logic                       busy_d, done_d, err_d, nes_d;
    logic [2:0]                 err_seg_d;
    logic                       first_cyc, start_req, latch;
    logic                       wr_req, rd_req, port_ack, last_byte;
    logic [7:0]                 port_rd_dat;

    logic [N_SEG*FL_AW-1:0]     fl_base_q;
    logic [N_SEG*SR_AW-1:0]     sr_base_q;
    logic [N_SEG*SEG_LEN_W-1:0] len_q;
    logic [FL_AW-1:0]           cur_fl_base;
    logic [SR_AW-1:0]           cur_sr_base;
    logic [SEG_LEN_W-1:0]       cur_len;

    assign cur_fl_base = fl_base_q[int'(seg)*FL_AW +: FL_AW];
    assign cur_sr_base = sr_base_q[int'(seg)*SR_AW +: SR_AW];
    assign cur_len     = len_q[int'(seg)*SEG_LEN_W +: SEG_LEN_W];
    assign idx_inc     = idx + SEG_LEN_W'(1);
    assign last_byte   = (idx_inc == cur_len);
    assign start_req   = i_start || ((AUTO_START != 0) && first_cyc);

    always_comb begin
        state_d   = state;
        seg_d     = seg;
        idx_d     = idx;
        retry_d   = retry;
        wcnt_d    = wcnt;
        fl_byte_d = fl_byte;
        fl_addr_d = o_fl_addr;
        busy_d    = o_busy;
        done_d    = o_done;
        err_d     = o_err;
        err_seg_d = o_err_seg;
        nes_d     = o_nes_rstn;
        wr_req    = 1'b0;
        rd_req    = 1'b0;
        latch     = 1'b0;

        unique case (state)
            IDLE, DONE, ERR: begin
                if (state == DONE) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    nes_d  = 1'b1;
                end
                if (state == ERR) begin
                    busy_d = 1'b0;
                    err_d  = 1'b1;
                end
                if (start_req) begin
                    latch     = 1'b1;
                    state_d   = SEG_INIT;
                    seg_d     = '0;
                    retry_d   = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    nes_d     = 1'b0;
                    err_seg_d = '0;
                end
            end
            SEG_INIT: begin
                idx_d  = '0;
                wcnt_d = '0;
                if (cur_len == '0) begin
                    state_d = NEXT_SEG;
                end else begin
                    state_d   = FL_RD;
                    fl_addr_d = cur_fl_base;
                end
            end
            FL_RD, VF_FL_RD: begin
                if (wcnt == FL_WAIT_C) begin
                    fl_byte_d = i_fl_rdata;
                    wcnt_d    = '0;
                    if (state == FL_RD) begin
                        wr_req  = 1'b1;
                        state_d = WR_SETUP;
                    end else begin
                        rd_req  = 1'b1;
                        state_d = VF_SR_RD;
                    end
                end else begin
                    wcnt_d = wcnt + 8'd1;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD: begin
                if (port_ack) begin
                    if (!last_byte) begin
                        idx_d     = idx_inc;
                        state_d   = FL_RD;
                        fl_addr_d = cur_fl_base + FL_AW'(idx_inc);
                    end else if (VERIFY != 0) begin
                        idx_d     = '0;
                        state_d   = VF_FL_RD;
                        fl_addr_d = cur_fl_base;
                    end else begin
                        state_d = NEXT_SEG;
                    end
                end
            end
            VF_SR_RD: begin
                if (port_ack) begin
                    if (port_rd_dat != fl_byte) begin
                        // A mismatch restarts the whole segment, not just the failing byte.
                        if (retry < MAX_RETRY_C) begin
                            retry_d = retry + RT_W'(1);
                            state_d = SEG_INIT;
                        end else begin
                            state_d   = ERR;
                            err_seg_d = seg;
                        end
                    end else if (last_byte) begin
                        state_d = NEXT_SEG;
                    end else begin
                        idx_d     = idx_inc;
                        state_d   = VF_FL_RD;
                        fl_addr_d = cur_fl_base + FL_AW'(idx_inc);
                    end
                end
            end
            NEXT_SEG: begin
                if (seg == LAST_SEG) begin
                    state_d = DONE;
                end else begin
                    seg_d   = seg + 3'd1;
                    retry_d = '0;
                    state_d = SEG_INIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            seg        <= '0;
            idx        <= '0;
            retry      <= '0;
            wcnt       <= '0;
            fl_byte    <= '0;
            first_cyc  <= 1'b1;
            o_fl_addr  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_err      <= 1'b0;
            o_err_seg  <= '0;
            o_nes_rstn <= 1'b0;
            fl_base_q  <= '0;
            sr_base_q  <= '0;
            len_q      <= '0;
        end else begin
            state      <= state_d;
            seg        <= seg_d;
            idx        <= idx_d;
            retry      <= retry_d;
            wcnt       <= wcnt_d;
            fl_byte    <= fl_byte_d;
            first_cyc  <= 1'b0;
            o_fl_addr  <= fl_addr_d;
            o_busy     <= busy_d;
            o_done     <= done_d;
            o_err      <= err_d;
            o_err_seg  <= err_seg_d;
            o_nes_rstn <= nes_d;
            if (latch) begin
                fl_base_q <= i_seg_fl_base;
                sr_base_q <= i_seg_sr_base;
                len_q     <= i_seg_len;
            end
        end
    end

    sram_byte_port #(
        .SR_AW (SR_AW)
    ) u_port (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .req_addr     (cur_sr_base + SR_AW'(idx >> 1)),
        .req_lane     (idx[0]),
        .req_wdat     (i_fl_rdata),
        .ack          (port_ack),
        .rd_dat       (port_rd_dat),
        .o_sram_addr  (o_sram_addr),
        .o_sram_wdata (o_sram_wdata),
        .i_sram_rdata (i_sram_rdata),
        .o_sram_oe_n  (o_sram_oe_n),
        .o_sram_we_n  (o_sram_we_n),
        .o_sram_ub_n  (o_sram_ub_n),
        .o_sram_lb_n  (o_sram_lb_n)
    );

endmodule

// File: doc/rom_loader_mc.md
Name: rom_loader_mc

Overview:
- Parametrised multi-segment flash-to-SRAM copy engine with optional readback verify, retry and NES core reset release.
- Successor to the single-image CHR loader in the device manager.
- Copies N_SEG independently placed segments from the 8-bit flash into the 16-bit SRAM.
- Holds the NES core in reset until every segment is loaded and, if enabled, verified.

Parameters:
FL_AW, 23, flash byte address width
SR_AW, 20, SRAM word address width
SEG_LEN_W, 16, segment length field width (bytes)
N_SEG, 2, number of copy segments (1..8)
FL_WAIT, 3, flash access cycles before data sample (>=1)
VERIFY, 1, 1 = readback-compare each segment after copy
MAX_RETRY, 2, re-copies allowed per segment after a verify mismatch
AUTO_START, 1, 1 = start automatically in the first cycle after reset deasserts

Ports:
i_clk  in  1  single clock (ppu clock domain)
i_rst  in  1  synchronous, active-high reset
i_start  in  1  start pulse; ignored while o_busy=1
i_seg_fl_base  in  N_SEG*FL_AW  flash byte base per segment, seg k at [k*FL_AW +: FL_AW]
i_seg_sr_base  in  N_SEG*SR_AW  SRAM word base per segment
i_seg_len  in  N_SEG*SEG_LEN_W  segment length in bytes; 0 = skip
o_fl_addr  out  FL_AW  flash byte address
i_fl_rdata  in  8  flash read data
o_sram_addr  out  SR_AW  SRAM word address
o_sram_wdata  out  16  write data, byte replicated on both halves
i_sram_rdata  in  16  SRAM read data
o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n  out  1 each  SRAM strobes, active low
o_busy  out  1  copy/verify in progress
o_done  out  1  level, all segments complete without error
o_err  out  1  level, verify failed after retries exhausted
o_err_seg  out  3  index of the failing segment
o_nes_rstn  out  1  active-low NES core reset; 1 only after success

Behaviour:
- Reset values:
  - o_fl_addr=0, o_sram_addr=0, o_sram_wdata=0.
  - All strobes=1.
  - o_busy=0, o_done=0, o_err=0, o_err_seg=0, o_nes_rstn=0.
  - Retry counter 0, FSM in IDLE.
- Reset mid-operation: every output returns to its reset value at the next edge; o_sram_we_n deasserts immediately.
- Segment inputs are latched at start and held constant for the whole run.
- FSM states: IDLE, SEG_INIT, FL_RD, WR_SETUP, WR_PULSE, WR_HOLD, VF_FL_RD, VF_SR_RD, NEXT_SEG, DONE, ERR.
- Start:
  - In IDLE, DONE or ERR, i_start=1 (or the first post-reset cycle when AUTO_START=1) goes to SEG_INIT with segment 0.
  - At that edge o_busy←1 and o_done, o_err, o_nes_rstn←0.
- SEG_INIT (1 cycle):
  - Byte index←0, retry←0 on first entry only.
  - len=0 → NEXT_SEG.
- Byte addressing:
  - Byte i of segment k: flash address = (fl_base+i) mod 2^FL_AW.
  - SRAM word = (sr_base+(i>>1)) mod 2^SR_AW.
  - Even i uses the lb lane, odd i uses the ub lane (little-endian).
- FL_RD: o_fl_addr driven on the first cycle; lasts FL_WAIT+1 cycles; i_fl_rdata latched on the last cycle.
- Write cycle, 1 cycle per state:
  - WR_SETUP: address, data and lane strobe valid, we_n=1.
  - WR_PULSE: we_n=0.
  - WR_HOLD: we_n=1, lane strobe still low.
  - The lane strobe rises on exit from WR_HOLD.
  - The other lane stays 1, so an odd final byte never touches ub.
- Per copied byte: FL_WAIT+4 cycles.
- After the last byte of a segment: VERIFY=1 → verify pass from i=0; VERIFY=0 → NEXT_SEG.
- Verify, per byte:
  - VF_FL_RD behaves as FL_RD.
  - VF_SR_RD lasts 2 cycles, oe_n=0 with lane low, and samples on the 2nd cycle.
  - The selected byte is compared with the latched flash byte.
  - Per byte: FL_WAIT+3 cycles.
- Verify mismatch:
  - retry<MAX_RETRY: retry++, return to SEG_INIT (same segment, re-copy).
  - Otherwise → ERR with o_err_seg=k.
- NEXT_SEG (1 cycle): k==N_SEG-1 → DONE, else k++ → SEG_INIT.
- DONE:
  - o_busy=0, o_done=1.
  - o_nes_rstn=1 from the same edge, held until the next start or reset.
- ERR: o_busy=0, o_err=1, o_nes_rstn stays 0.
- Arithmetic: byte index and length are SEG_LEN_W bits; all address additions wrap silently.
- Cycle count from start edge to o_done=1 with no retries:
  - VERIFY=0: 1 + Σ(1 + len_k·(FL_WAIT+4)) + 1 per segment? No — exactly N_SEG·2 + Σlen_k·(FL_WAIT+4) + 1.
  - VERIFY=1: add Σlen_k·(FL_WAIT+3).

Decomposition:
- Package rom_loader_pkg holds the state enum encoding, lane select constants (LANE_LO, LANE_HI) and a function for per-byte cycle counts used by the bench.
- One sub-module, sram_byte_port: performs the 3-cycle byte write and 2-cycle byte read with lane select, with a req/ack handshake to the main FSM.

Test Plan:
- Basic copy:
  - Stimulus: N_SEG=2, FL_WAIT=3, VERIFY=0; seg0 fl 0x000100, sr 0x00040, len 4, flash bytes 11 22 33 44; seg1 len 0.
  - Response: SRAM[0x40]=0x2211, SRAM[0x41]=0x4433; o_done at cycle 4+28+1=33; o_nes_rstn=1 the same cycle.
- Odd length:
  - Stimulus: len 3, flash AA BB CC, SRAM[0x41] preset 0xFFFF.
  - Response: SRAM[0x41]=0xFFCC; ub_n never low for word 0x41.
- Transient verify fault:
  - Stimulus: VERIFY=1; model corrupts the first write of byte 2 once.
  - Response: one re-copy of seg0; o_done=1, o_err=0.
- Persistent verify fault:
  - Stimulus: VERIFY=1; persistent corruption in seg1.
  - Response: 3 copy attempts (MAX_RETRY=2); o_err=1, o_err_seg=1, o_nes_rstn stays 0.
- Reset mid-write:
  - Stimulus: i_rst=1 during WR_PULSE.
  - Response: next cycle we_n=1 and all outputs at reset values; with AUTO_START=1 the copy restarts from seg0, byte 0.
- Restart and wrap:
  - Stimulus: i_start while busy; i_start after DONE; fl_base 0x7FFFFE, len 4.
  - Response: the start while busy is ignored; the start after DONE drops o_nes_rstn and re-runs; flash addresses 7FFFFE, 7FFFFF, 000000, 000001.
